io_port_ctrl: RTL and testbench
===============================

# io_port_ctrl

Memory-mapped I/O peripheral for the p18240 board build. It sits on the processor's memory bus beside `memorySystem` and decodes accesses to 0xFF00–0xFF07. Those accesses drive the seven-segment and LED values and return switch and pushbutton state. The block also provides a polled prescaled down-counter timer. Its `disp1`/`disp0` outputs feed `SevenSegmentControl` in place of the hard-wired debug mux whenever the top level selects I/O mode.

## Interface
- `PRESCALE`, default 1000: clock cycles per timer tick. Legal range is 1–65535.
- `BASE`, default 16'hFF00: I/O window base address. The low 3 address bits are decoded; bits [15:3] must equal `BASE[15:3]`.

Ports:
- `clock` in 1: system clock. All state changes on its rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `address` in 16: memory address (`memAddr`).
- `re_L` in 1: read enable, active low.
- `we_L` in 1: write enable, active low.
- `dataIn` in 16: write data sampled from the data bus.
- `dataOut` out 16: read data, valid while `dataOutEn`=1. Drives 0 otherwise.
- `dataOutEn` out 1: high when `re_L`=0 and the address hits the window. The top level uses it to tri-state `dataOut` onto `dataBus`.
- `SW` in 18: board switches, already static levels.
- `KEY_L` in 2: pushbuttons KEY[3:2], active low, asynchronous.
- `disp1` out 16: upper four display digits.
- `disp0` out 16: lower four display digits.
- `ledg` out 9: green LED values.

## Operation
- Hit = (`address[15:3]`==`BASE[15:3]`). Register index = `address[2:0]`.
- Registers (R = readable, W = writable, W1C = write-1-to-clear):
  - 0 DISP0 R/W: drives `disp0`.
  - 1 DISP1 R/W: drives `disp1`.
  - 2 LEDG R/W: bits [8:0] drive `ledg`; bits [15:9] read 0.
  - 3 SWLO R: `SW[15:0]`.
  - 4 KEYST: bits [1:0] = `SW[17:16]` (R); bits [5:4] = press flags for KEY3/KEY2 (R/W1C); bits [9:8] = synced pressed level (R, 1 = pressed); other bits read 0.
  - 5 TLOAD R/W: timer reload value.
  - 6 TCOUNT R: current count.
  - 7 TCTRL: bit0 `en` (R/W), bit1 `auto` (R/W), bit15 `expired` (R/W1C); other bits read 0.
- Writes take effect on the rising edge with `we_L`=0 and a hit. Writes to read-only registers or bits are ignored.
- Reads are combinational from current register state and have no side effects. If `re_L` and `we_L` are both low, the write proceeds and the read returns pre-write data.
- Keys:
  - Each of the two keys has a 2-flop synchronizer.
  - A press is a synced 1→0 transition; it sets the corresponding flag.
  - If a press and a W1C of the same flag occur in the same cycle, the set wins.
- Timer:
  - The prescaler counts 0..`PRESCALE`-1 while `en`=1. A tick is asserted in the cycle the prescaler equals `PRESCALE`-1, and the prescaler then wraps to 0.
  - While `en`=0 the prescaler is held at 0.
  - Writing TCTRL with `en`=1 when `en` was 0 loads TCOUNT←TLOAD and clears the prescaler.
  - Writing TLOAD while the timer runs does not disturb TCOUNT.
  - On a tick:
    - If TCOUNT ≤ 1: set `expired`. TCOUNT ← (`auto` ? TLOAD : 0). If `auto`=0, clear `en`.
    - Otherwise TCOUNT ← TCOUNT−1.
  - With TLOAD=0 and `auto`=1, the timer expires on every tick.
  - If an expiry and a W1C of `expired` occur in the same cycle, the set wins.
  - If a tick and a TCTRL write occur in the same cycle, the written `en`/`auto` values take priority over the one-shot `en` clear.

## Timing
- Reset values (asynchronous on `reset_L`=0):
  - all registers, prescaler and synchronizers = 0, except synchronizer flops, which reset to 1 (released);
  - `disp0`=`disp1`=0, `ledg`=0, `dataOut`=0, `dataOutEn`=0.
- `dataOut` and `dataOutEn` are combinational from `address`, `re_L` and state, so the read has zero-cycle latency within the access cycle.
- A write is visible on `disp*`/`ledg` and on read-back in the cycle after the write edge.
- Key latency: a press is reflected in the flag 3 rising edges after `KEY_L` falls, when it is stable relative to the sample edge.
- Timer period with `auto`=1:
  - expiry every (TLOAD)·`PRESCALE` cycles for TLOAD ≥ 1;
  - every `PRESCALE` cycles for TLOAD = 0.
- Asserting reset mid-count aborts the timer immediately. No expiry is generated.

## Test plan
1. Reset, then write 16'h1234 to FF00 and 16'hABCD to FF01 → next cycle `disp0`=1234 and `disp1`=ABCD; reading FF00 returns 1234 with `dataOutEn`=1. A read of FF08 gives `dataOutEn`=0.
2. Set `SW`=18'h2_5A5A and read FF03 and FF04 → 5A5A and 0002. A write to FF03 is ignored.
3. With `PRESCALE`=4, TLOAD=3, write TCTRL=1 (one-shot) → `expired` sets 12 cycles after the write edge, TCOUNT=0 and `en`=0. W1C 16'h8000 to FF07 → TCTRL reads 0.
4. With `PRESCALE`=4, TLOAD=2, TCTRL=3 (auto) → `expired` sets at cycle 8. Clear it; it sets again 8 cycles later and TCOUNT reloads to 2 each time. A W1C in the same cycle as an expiry leaves `expired`=1.
5. Pulse `KEY_L[1]` low for 5 cycles → FF04 bit5 = 1 and bit9 = 1 while the key is held. W1C 16'h0020 → bit5 = 0. A press coincident with the W1C leaves the flag set.
6. Assert `reset_L` low mid-count with the timer running → all outputs return to 0 immediately and `expired` stays 0 after release.

Source files
------------

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O window for the p18240 board build.
// It decodes eight registers at BASE..BASE+7. These drive the display
// digits and the green LEDs, return switch and pushbutton state, and
// expose a polled, prescaled down-counter timer.
module io_port_ctrl #(
    parameter int unsigned PRESCALE = 1000,
    parameter logic [15:0] BASE     = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic [15:0] address,
    input  logic        re_L,
    input  logic        we_L,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut,
    output logic        dataOutEn,
    input  logic [17:0] SW,
    input  logic [1:0]  KEY_L,
    output logic [15:0] disp1,
    output logic [15:0] disp0,
    output logic [8:0]  ledg
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    localparam logic [2:0] R_DISP0  = 3'd0;
    localparam logic [2:0] R_DISP1  = 3'd1;
    localparam logic [2:0] R_LEDG   = 3'd2;
    localparam logic [2:0] R_SWLO   = 3'd3;
    localparam logic [2:0] R_KEYST  = 3'd4;
    localparam logic [2:0] R_TLOAD  = 3'd5;
    localparam logic [2:0] R_TCOUNT = 3'd6;
    localparam logic [2:0] R_TCTRL  = 3'd7;

    logic        hit;
    logic [2:0]  idx;
    logic        wr_hit;

    logic [15:0] disp0_r;
    logic [15:0] disp1_r;
    logic [8:0]  ledg_r;

    // Two synchronizer stages plus one history flop for the edge detect.
    // All idle high, so reset never looks like a press.
    logic [1:0]  key_s1;
    logic [1:0]  key_s2;
    logic [1:0]  key_s3;
    logic [1:0]  press;
    logic [1:0]  flags;
    logic [1:0]  flags_nx;

    logic [15:0] tload;
    logic [15:0] tcount;
    logic [15:0] tcount_nx;
    logic [15:0] presc;
    logic        t_en;
    logic        t_auto;
    logic        t_exp;
    logic        en_nx;
    logic        auto_nx;
    logic        exp_nx;
    logic        tick;
    logic        expire;

    logic [15:0] rdata;

    assign hit    = (address[15:3] == BASE[15:3]);
    assign idx    = address[2:0];
    assign wr_hit = hit && !we_L;

    assign press  = key_s3 & ~key_s2;
    assign tick   = t_en && (presc == PS_LAST);
    assign expire = tick && (tcount <= 16'd1);

    assign disp0 = disp0_r;
    assign disp1 = disp1_r;
    assign ledg  = ledg_r;

    // Plain output registers: display digits and green LEDs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            disp0_r <= '0;
            disp1_r <= '0;
            ledg_r  <= '0;
        end else if (wr_hit) begin
            case (idx)
                R_DISP0: disp0_r <= dataIn;
                R_DISP1: disp1_r <= dataIn;
                R_LEDG:  ledg_r  <= dataIn[8:0];
                default: ;
            endcase
        end
    end

    // Pushbutton synchronizers and edge history.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            key_s3 <= 2'b11;
        end else begin
            key_s1 <= KEY_L;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    // Press flags: W1C first, then a new press sets the flag, so a press wins.
    always_comb begin
        flags_nx = flags;
        if (wr_hit && idx == R_KEYST)
            flags_nx = flags_nx & ~dataIn[5:4];
        flags_nx = flags_nx | press;
    end

    // Press flag register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) flags <= '0;
        else          flags <= flags_nx;
    end

    // Timer next state. Tick effects are applied first so that a TCTRL write
    // in the same cycle overrides the one-shot en clear. Expiry is applied
    // last so that it wins over a W1C.
    always_comb begin
        tcount_nx = tcount;
        en_nx     = t_en;
        auto_nx   = t_auto;
        exp_nx    = t_exp;
        if (tick) begin
            if (tcount <= 16'd1) begin
                tcount_nx = t_auto ? tload : 16'd0;
                if (!t_auto) en_nx = 1'b0;
            end else begin
                tcount_nx = tcount - 16'd1;
            end
        end
        if (wr_hit && idx == R_TCTRL) begin
            en_nx   = dataIn[0];
            auto_nx = dataIn[1];
            if (dataIn[0] && !t_en) tcount_nx = tload;
            if (dataIn[15]) exp_nx = 1'b0;
        end
        if (expire) exp_nx = 1'b1;
    end

    // Timer state, reload register and prescaler. The prescaler sits at 0
    // whenever the timer is disabled, so a fresh enable always starts a full
    // prescale period.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            tload  <= '0;
            tcount <= '0;
            presc  <= '0;
            t_en   <= 1'b0;
            t_auto <= 1'b0;
            t_exp  <= 1'b0;
        end else begin
            if (wr_hit && idx == R_TLOAD) tload <= dataIn;
            tcount <= tcount_nx;
            t_en   <= en_nx;
            t_auto <= auto_nx;
            t_exp  <= exp_nx;
            if (!t_en || tick) presc <= '0;
            else               presc <= presc + 16'd1;
        end
    end

    // Read mux: combinational and free of side effects.
    always_comb begin
        rdata = '0;
        case (idx)
            R_DISP0:  rdata = disp0_r;
            R_DISP1:  rdata = disp1_r;
            R_LEDG:   rdata = {7'b0, ledg_r};
            R_SWLO:   rdata = SW[15:0];
            R_KEYST:  rdata = {6'b0, ~key_s2, 2'b0, flags, 2'b0, SW[17:16]};
            R_TLOAD:  rdata = tload;
            R_TCOUNT: rdata = tcount;
            R_TCTRL:  rdata = {t_exp, 13'b0, t_auto, t_en};
            default:  rdata = '0;
        endcase
    end

    assign dataOutEn = hit && !re_L;
    assign dataOut   = dataOutEn ? rdata : 16'h0000;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl, built with PRESCALE = 4.
module tb_io_port_ctrl;

    logic        clock = 1'b0;
    logic        reset_L;
    logic [15:0] address;
    logic        re_L;
    logic        we_L;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        dataOutEn;
    logic [17:0] SW;
    logic [1:0]  KEY_L;
    logic [15:0] disp1;
    logic [15:0] disp0;
    logic [8:0]  ledg;

    int nvec = 0;
    int nerr = 0;

    io_port_ctrl #(.PRESCALE(4), .BASE(16'hFF00)) dut (
        .clock(clock), .reset_L(reset_L), .address(address), .re_L(re_L),
        .we_L(we_L), .dataIn(dataIn), .dataOut(dataOut), .dataOutEn(dataOutEn),
        .SW(SW), .KEY_L(KEY_L), .disp1(disp1), .disp0(disp0), .ledg(ledg)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [17:0] sw;
        logic [15:0] exp_dout;
        bit          exp_en;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
        logic [8:0]  exp_ledg;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus write: drives for one rising edge, returns at edge + 1.
    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        address = a; dataIn = d; we_L = 1'b0; re_L = 1'b1;
        @(posedge clock); #1;
        we_L = 1'b1;
    endtask

    // Bus read: purely combinational, no clock edge consumed.
    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d, output logic en);
        address = a; re_L = 1'b0;
        #1;
        d = dataOut; en = dataOutEn;
        re_L = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        en;
        bus_rd(a, d, en);
        check({name, "_en"}, {31'b0, en}, 32'd1);
        check(name, {16'b0, d}, {16'b0, exp});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference model for the plain storage registers.
    logic [15:0] m_d0, m_d1, m_tload;
    logic [8:0]  m_ledg;

    function automatic logic [15:0] model_read(input logic [2:0] i, input logic [17:0] sw);
        case (i)
            3'd0: return m_d0;
            3'd1: return m_d1;
            3'd2: return {7'b0, m_ledg};
            3'd3: return sw[15:0];
            3'd4: return {14'b0, sw[17:16]};
            3'd5: return m_tload;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        reset_L = 1'b0; address = '0; re_L = 1'b1; we_L = 1'b1;
        dataIn = '0; SW = '0; KEY_L = 2'b11;

        //            wr rd addr      wdata    sw        dout     en d0       d1       ledg
        tv[0]  = '{0, 0, 16'hFF00, 16'h0000, 18'h0,     16'h0000, 0, 16'h0000, 16'h0000, 9'h000};
        tv[1]  = '{1, 0, 16'hFF00, 16'h1234, 18'h0,     16'h0000, 0, 16'h1234, 16'h0000, 9'h000};
        tv[2]  = '{1, 0, 16'hFF01, 16'hABCD, 18'h0,     16'h0000, 0, 16'h1234, 16'hABCD, 9'h000};
        tv[3]  = '{0, 1, 16'hFF00, 16'h0000, 18'h0,     16'h1234, 1, 16'h1234, 16'hABCD, 9'h000};
        tv[4]  = '{0, 1, 16'hFF08, 16'h0000, 18'h0,     16'h0000, 0, 16'h1234, 16'hABCD, 9'h000};
        tv[5]  = '{0, 1, 16'hFF03, 16'h0000, 18'h25A5A, 16'h5A5A, 1, 16'h1234, 16'hABCD, 9'h000};
        tv[6]  = '{0, 1, 16'hFF04, 16'h0000, 18'h25A5A, 16'h0002, 1, 16'h1234, 16'hABCD, 9'h000};
        tv[7]  = '{1, 0, 16'hFF03, 16'hFFFF, 18'h25A5A, 16'h0000, 0, 16'h1234, 16'hABCD, 9'h000};
        tv[8]  = '{0, 1, 16'hFF03, 16'h0000, 18'h25A5A, 16'h5A5A, 1, 16'h1234, 16'hABCD, 9'h000};
        tv[9]  = '{1, 1, 16'hFF02, 16'hFFFF, 18'h25A5A, 16'h0000, 1, 16'h1234, 16'hABCD, 9'h1FF};
        tv[10] = '{0, 1, 16'hFF02, 16'h0000, 18'h25A5A, 16'h01FF, 1, 16'h1234, 16'hABCD, 9'h1FF};
        tv[11] = '{0, 1, 16'hFF07, 16'h0000, 18'h25A5A, 16'h0000, 1, 16'h1234, 16'hABCD, 9'h1FF};

        // Reset state.
        #13;
        check("rst_disp0", {16'b0, disp0}, 32'h0);
        check("rst_disp1", {16'b0, disp1}, 32'h0);
        check("rst_ledg", {23'b0, ledg}, 32'h0);
        check("rst_dout", {16'b0, dataOut}, 32'h0);
        check("rst_douten", {31'b0, dataOutEn}, 32'h0);
        #10 reset_L = 1'b1;
        cycles(1);

        // Directed register vectors.
        for (int i = 0; i < 12; i++) begin
            SW = tv[i].sw; address = tv[i].addr; dataIn = tv[i].wdata;
            re_L = !tv[i].rd; we_L = !tv[i].wr;
            #1;
            check($sformatf("tv%0d_dout", i), {16'b0, dataOut}, {16'b0, tv[i].exp_dout});
            check($sformatf("tv%0d_en", i), {31'b0, dataOutEn}, {31'b0, tv[i].exp_en});
            @(posedge clock); #1;
            re_L = 1'b1; we_L = 1'b1;
            check($sformatf("tv%0d_d0", i), {16'b0, disp0}, {16'b0, tv[i].exp_d0});
            check($sformatf("tv%0d_d1", i), {16'b0, disp1}, {16'b0, tv[i].exp_d1});
            check($sformatf("tv%0d_ledg", i), {23'b0, ledg}, {23'b0, tv[i].exp_ledg});
        end

        // Randomized register traffic against the model.
        m_d0 = 16'h1234; m_d1 = 16'hABCD; m_ledg = 9'h1FF; m_tload = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a, d, exp_rd;
            logic        r, w, h;
            logic [17:0] sw;
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else                           a = 16'hFF00 | 16'($urandom_range(0, 7));
            d  = 16'($urandom);
            sw = 18'($urandom);
            r  = 1'($urandom);
            w  = 1'($urandom);
            h  = (a >= 16'hFF00 && a <= 16'hFF07);
            if (h && a[2:0] == 3'd7) w = 1'b0;
            SW = sw; address = a; dataIn = d; re_L = !r; we_L = !w;
            #1;
            exp_rd = (h && r) ? model_read(a[2:0], sw) : 16'h0000;
            check("rnd_en", {31'b0, dataOutEn}, {31'b0, h && r});
            check("rnd_dout", {16'b0, dataOut}, {16'b0, exp_rd});
            @(posedge clock); #1;
            re_L = 1'b1; we_L = 1'b1;
            if (h && w) begin
                case (a[2:0])
                    3'd0: m_d0 = d;
                    3'd1: m_d1 = d;
                    3'd2: m_ledg = d[8:0];
                    3'd5: m_tload = d;
                    default: ;
                endcase
            end
            check("rnd_d0", {16'b0, disp0}, {16'b0, m_d0});
            check("rnd_d1", {16'b0, disp1}, {16'b0, m_d1});
            check("rnd_ledg", {23'b0, ledg}, {23'b0, m_ledg});
        end
        SW = 18'h25A5A;

        // One-shot timer: TLOAD=3, PRESCALE=4 -> expiry 12 cycles after the enable.
        bus_wr(16'hFF05, 16'd3);
        bus_wr(16'hFF07, 16'h0001);
        cycles(11);
        rd_check("os_tctrl_pre", 16'hFF07, 16'h0001);
        rd_check("os_tcount_pre", 16'hFF06, 16'd1);
        cycles(1);
        rd_check("os_tctrl_exp", 16'hFF07, 16'h8000);
        rd_check("os_tcount_exp", 16'hFF06, 16'd0);
        bus_wr(16'hFF07, 16'h8000);
        rd_check("os_tctrl_clr", 16'hFF07, 16'h0000);

        // Auto-reload timer: TLOAD=2 -> expiry every 8 cycles.
        bus_wr(16'hFF05, 16'd2);
        bus_wr(16'hFF07, 16'h0003);
        cycles(7);
        rd_check("ar_pre1", 16'hFF07, 16'h0003);
        cycles(1);
        rd_check("ar_exp1", 16'hFF07, 16'h8003);
        rd_check("ar_cnt1", 16'hFF06, 16'd2);
        bus_wr(16'hFF07, 16'h8003);
        rd_check("ar_clr1", 16'hFF07, 16'h0003);
        cycles(6);
        rd_check("ar_pre2", 16'hFF07, 16'h0003);
        cycles(1);
        rd_check("ar_exp2", 16'hFF07, 16'h8003);
        rd_check("ar_cnt2", 16'hFF06, 16'd2);
        bus_wr(16'hFF07, 16'h8003);
        cycles(6);
        bus_wr(16'hFF07, 16'h8003);
        rd_check("ar_w1c_race", 16'hFF07, 16'h8003);
        rd_check("ar_cnt3", 16'hFF06, 16'd2);
        bus_wr(16'hFF07, 16'h8000);
        rd_check("ar_off", 16'hFF07, 16'h0000);

        // Pushbutton KEY3 (KEY_L[1]) held for 5 cycles.
        KEY_L = 2'b01;
        cycles(2);
        rd_check("key_sync2", 16'hFF04, 16'h0202);
        cycles(1);
        rd_check("key_flag", 16'hFF04, 16'h0222);
        cycles(2);
        rd_check("key_held", 16'hFF04, 16'h0222);
        KEY_L = 2'b11;
        cycles(3);
        rd_check("key_rel", 16'hFF04, 16'h0022);
        bus_wr(16'hFF04, 16'h0020);
        rd_check("key_w1c", 16'hFF04, 16'h0002);
        KEY_L = 2'b01;
        cycles(2);
        bus_wr(16'hFF04, 16'h0020);
        rd_check("key_race", 16'hFF04, 16'h0222);
        KEY_L = 2'b11;
        cycles(4);

        // Reset in the middle of a running count.
        bus_wr(16'hFF05, 16'd5);
        bus_wr(16'hFF07, 16'h0003);
        cycles(6);
        re_L = 1'b1; address = 16'hFF07;
        reset_L = 1'b0;
        #1;
        check("mid_rst_disp0", {16'b0, disp0}, 32'h0);
        check("mid_rst_disp1", {16'b0, disp1}, 32'h0);
        check("mid_rst_ledg", {23'b0, ledg}, 32'h0);
        check("mid_rst_dout", {16'b0, dataOut}, 32'h0);
        check("mid_rst_douten", {31'b0, dataOutEn}, 32'h0);
        #2 reset_L = 1'b1;
        cycles(30);
        rd_check("post_rst_tctrl", 16'hFF07, 16'h0000);
        rd_check("post_rst_tcount", 16'hFF06, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
